multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the iterative 32-bit signed multiply/divide for mul/div instructions decoded in X.
//  Accepts one op from the pipeline, stalls F/D/X while iterating and returns the result with its writeback register.
//  Reports mul overflow / div-by-zero by redirecting writeback to rstatus.
//  Sits beside the ALU in X; its done/result feed the X/M latch mux.
// PARAMETERS
//  WIDTH         32  operand/result width; iteration count = WIDTH
//  RSTATUS_REG   30  writeback register on exception
//  MUL_EXC_CODE  4   value written to rstatus on mul overflow
//  DIV_EXC_CODE  5   value written to rstatus on divide by zero
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      X stage holds mul or div this cycle
//  is_div     in   1      1 = div, 0 = mul; sampled with start
//  op_a       in   WIDTH  dividend / multiplicand (signed)
//  op_b       in   WIDTH  divisor / multiplier (signed)
//  rd_in      in   5      instruction destination register
//  flush      in   1      branch/jump squash of the X instruction
//  stall      out  1      hold PC, F/D, D/X latches
//  busy       out  1      op in flight (RUN or DONE)
//  done       out  1      result valid this cycle; pipeline latches into X/M
//  result     out  WIDTH  product/quotient, or exception code
//  rd_out     out  5      writeback register for result
//  exception  out  1      result is an rstatus code
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, count=0; stall/busy/done/exception=0, result=0, rd_out=0. Applies mid-operation; op discarded.
//  States: IDLE -> RUN on accepted start with op_b!=0 or !is_div; IDLE -> DONE on div with op_b==0.
//   RUN -> DONE when count==WIDTH-1; DONE -> IDLE unconditionally; any state -> IDLE on flush (DONE: see below).
//  Accept: start & IDLE & !flush. Latch |op_a|, |op_b|, result sign, is_div, rd_in; count=0.
//  start while RUN/DONE ignored (pipeline is stalled, no re-issue).
//  stall = (IDLE & start & !flush) | RUN. Low in DONE so the instruction advances with the result.
//  Latency: done high exactly WIDTH+1 cycles after the accepting edge (33 at default); div-by-zero: 1 cycle.
//  MUL: unsigned shift-add on magnitudes into 2*WIDTH accumulator, one bit per RUN cycle; sign applied in DONE.
//   Overflow if signed 64-bit product != sign-extension of its low 32 bits.
//  DIV: restoring, one quotient bit per RUN cycle; quotient truncates toward zero; remainder discarded.
//   INT_MIN / -1 -> 0x8000_0000, no exception.
//  Exception (mul overflow or div by zero): exception=1, rd_out=RSTATUS_REG, result=MUL_EXC_CODE/DIV_EXC_CODE.
//   Otherwise rd_out=latched rd, exception=0.
//  result/rd_out/exception registered, stable for the whole DONE cycle; done = (state==DONE) & !flush.
//  flush in RUN: IDLE next edge, no done. flush with start in IDLE: start ignored. flush in DONE: done suppressed.
//  rd 0 destination passes through unchanged; regfile ignores the write.
// STRUCTURE
//  multdiv_pkg: state encoding (IDLE/RUN/DONE), RSTATUS_REG, MUL_EXC_CODE, DIV_EXC_CODE, WIDTH default.
//  One sub-module multdiv_step: combinational single-iteration datapath (add-shift or subtract-restore) selected by is_div.
//  Sequencer holds FSM, iteration counter, operand/accumulator registers, sign fix-up and exception mux.
// TESTING
//  mul 7 * -6, rd=3 -> stall 33 cycles, done at +33, result=0xFFFFFFD6, rd_out=3, exception=0.
//  mul 0x10000 * 0x10000, rd=4 -> done at +33, exception=1, rd_out=30, result=4.
//  div -17 / 5, rd=5 -> done at +33, result=0xFFFFFFFD (-3); 0x80000000 / -1 -> 0x80000000, exception=0.
//  div 9 / 0, rd=6 -> done 1 cycle after start, rd_out=30, result=5, stall high only in start cycle.
//  flush on RUN cycle 10 -> no done; busy=0 next cycle; next start (mul 2*3) -> result 6 at +33.
//  reset_n low on RUN cycle 5 -> all outputs 0 without waiting for clock; start after release works normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
package multdiv_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int RSTATUS_REG  = 30;
  localparam int MUL_EXC_CODE = 4;
  localparam int DIV_EXC_CODE = 5;

  // FSM encoding kept as plain constants so legacy tools can dump it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared multiply/divide datapath.
//   mul: shift-add on {hi, lo}, lo starts as the multiplier magnitude.
//   div: restoring step on {hi, lo}, hi is the partial remainder and lo
//        shifts the dividend out while shifting quotient bits in.
module multdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // Select add-shift or subtract-restore for this iteration
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    ge      = (shifted >= {1'b0, opnd});
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      // remainder always stays below the divisor, so WIDTH bits suffice
      hi_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], ge};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative 32-bit signed mul/div sequencer sitting beside the ALU in X.
// Stalls the front of the pipe while iterating, then presents the result
// (or an rstatus exception code) for one DONE cycle.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int RSTATUS_REG  = multdiv_pkg::RSTATUS_REG,
  parameter int MUL_EXC_CODE = multdiv_pkg::MUL_EXC_CODE,
  parameter int DIV_EXC_CODE = multdiv_pkg::DIV_EXC_CODE
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    is_div,
  input  logic signed [WIDTH-1:0] op_a,
  input  logic signed [WIDTH-1:0] op_b,
  input  logic [4:0]              rd_in,
  input  logic                    flush,
  output logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        result,
  output logic [4:0]              rd_out,
  output logic                    exception
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
  logic               div_q, neg_q;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic               accept, last;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic               mul_ovf;

  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return v[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix_wide(input logic [2*WIDTH-1:0] m,
                                                       input logic neg);
    return neg ? (~m + 1'b1) : m;
  endfunction

  assign accept = (state_q == ST_IDLE) & start & ~flush;
  assign last   = (count_q == CW'(WIDTH - 1));
  assign stall  = accept | (state_q == ST_RUN);
  assign busy   = (state_q == ST_RUN) | (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE) & ~flush;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  // Sign fix-up of the final iteration output; overflow when the signed
  // product does not fit in WIDTH bits (upper bits not a sign extension)
  always_comb begin
    prod_s  = sign_fix_wide({hi_next, lo_next}, neg_q);
    quo_s   = sign_fix(lo_next, neg_q);
    mul_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1]) || ~(|prod_s[2*WIDTH-1:WIDTH-1]));
  end

  // Operand/accumulator registers: load magnitudes on accept, iterate in RUN
  always_ff @(posedge clock) begin
    if (accept) begin
      hi_q   <= '0;
      lo_q   <= is_div ? mag_of(op_a) : mag_of(op_b);
      opnd_q <= is_div ? mag_of(op_b) : mag_of(op_a);
      div_q  <= is_div;
      neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      rd_q   <= rd_in;
    end else if (state_q == ST_RUN) begin
      hi_q   <= hi_next;
      lo_q   <= lo_next;
    end
  end

  // FSM, iteration counter and registered result/exception mux
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      result    <= '0;
      rd_out    <= '0;
      exception <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            count_q <= '0;
            if (is_div && (op_b == '0)) begin
              state_q   <= ST_DONE;
              result    <= WIDTH'(DIV_EXC_CODE);
              rd_out    <= 5'(RSTATUS_REG);
              exception <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (last) begin
            state_q <= ST_DONE;
            if (div_q) begin
              result    <= quo_s;
              rd_out    <= rd_q;
              exception <= 1'b0;
            end else if (mul_ovf) begin
              result    <= WIDTH'(MUL_EXC_CODE);
              rd_out    <= 5'(RSTATUS_REG);
              exception <= 1'b1;
            end else begin
              result    <= prod_s[WIDTH-1:0];
              rd_out    <= rd_q;
              exception <= 1'b0;
            end
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  localparam int W = 32;

  logic                clock = 1'b0;
  logic                reset_n, start, is_div, flush;
  logic signed [W-1:0] op_a, op_b;
  logic [4:0]          rd_in;
  logic                stall, busy, done, exception;
  logic [W-1:0]        result;
  logic [4:0]          rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .is_div    (is_div),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .exception (exception)
  );

  // Present one op for a single cycle; st0 is stall seen in the start cycle
  task automatic issue(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, output logic st0);
    @(negedge clock);
    is_div = div; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1 st0 = stall;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Cycle 1 is the one after the accepting edge; returns -1 on timeout
  task automatic wait_done(output int lat, output int stall_run, output logic st_done,
                           output logic [W-1:0] res, output logic [4:0] rdo, output logic exc);
    lat = -1; stall_run = 0; st_done = 1'b0; res = '0; rdo = '0; exc = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (done === 1'b1) begin
        lat = n; res = result; rdo = rd_out; exc = exception; st_done = stall;
        break;
      end
      if (stall === 1'b1) stall_run++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; flush = 1'b0; is_div = 1'b0;
    op_a = '0; op_b = '0; rd_in = '0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0)     begin n_bad++; $display("FAIL reset stall: got %b expected 0", stall); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset done: got %b expected 0", done); end
    n_cmp++; if (result !== 32'h0)   begin n_bad++; $display("FAIL reset result: got %h expected 0", result); end
    n_cmp++; if (rd_out !== 5'd0)    begin n_bad++; $display("FAIL reset rd_out: got %0d expected 0", rd_out); end
    n_cmp++; if (exception !== 1'b0) begin n_bad++; $display("FAIL reset exception: got %b expected 0", exception); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mul_basic();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b0, 32'd7, -32'sd6, 5'd3, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 33)           begin n_bad++; $display("FAIL mul_basic latency: got %0d expected 33", lat); end
    n_cmp++; if (sr + int'(st0) !== 33) begin n_bad++; $display("FAIL mul_basic stall cycles: got %0d expected 33", sr + int'(st0)); end
    n_cmp++; if (res !== 32'hFFFFFFD6) begin n_bad++; $display("FAIL mul_basic result: got %h expected ffffffd6", res); end
    n_cmp++; if (rdo !== 5'd3)         begin n_bad++; $display("FAIL mul_basic rd_out: got %0d expected 3", rdo); end
    n_cmp++; if (exc !== 1'b0)         begin n_bad++; $display("FAIL mul_basic exception: got %b expected 0", exc); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mul_basic after done busy/done: got %b%b expected 00", busy, done); end
  endtask

  task automatic test_mul_overflow();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b0, 32'h10000, 32'h10000, 5'd4, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 33)   begin n_bad++; $display("FAIL mul_ovf latency: got %0d expected 33", lat); end
    n_cmp++; if (exc !== 1'b1) begin n_bad++; $display("FAIL mul_ovf exception: got %b expected 1", exc); end
    n_cmp++; if (rdo !== 5'd30) begin n_bad++; $display("FAIL mul_ovf rd_out: got %0d expected 30", rdo); end
    n_cmp++; if (res !== 32'd4) begin n_bad++; $display("FAIL mul_ovf result: got %h expected 4", res); end
    // +2^31 does not fit in a signed 32-bit result
    issue(1'b0, 32'h8000, 32'h10000, 5'd11, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (exc !== 1'b1 || res !== 32'd4) begin n_bad++; $display("FAIL mul_ovf_pos2e31 exc/result: got %b/%h expected 1/4", exc, res); end
  endtask

  task automatic test_mul_min_boundary();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    // -2^31 is exactly representable; rd 0 must pass through
    issue(1'b0, -32'sd65536, 32'sd32768, 5'd0, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (res !== 32'h80000000) begin n_bad++; $display("FAIL mul_min result: got %h expected 80000000", res); end
    n_cmp++; if (exc !== 1'b0)         begin n_bad++; $display("FAIL mul_min exception: got %b expected 0", exc); end
    n_cmp++; if (rdo !== 5'd0)         begin n_bad++; $display("FAIL mul_min rd_out: got %0d expected 0", rdo); end
  endtask

  task automatic test_div_signed();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b1, -32'sd17, 32'sd5, 5'd5, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 33)           begin n_bad++; $display("FAIL div_signed latency: got %0d expected 33", lat); end
    n_cmp++; if (res !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_signed result: got %h expected fffffffd", res); end
    n_cmp++; if (rdo !== 5'd5 || exc !== 1'b0) begin n_bad++; $display("FAIL div_signed rd/exc: got %0d/%b expected 5/0", rdo, exc); end
    issue(1'b1, 32'sd100, -32'sd7, 5'd12, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (res !== 32'hFFFFFFF2) begin n_bad++; $display("FAIL div_neg_divisor result: got %h expected fffffff2", res); end
  endtask

  task automatic test_div_int_min();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b1, 32'h80000000, -32'sd1, 5'd13, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (res !== 32'h80000000) begin n_bad++; $display("FAIL div_int_min result: got %h expected 80000000", res); end
    n_cmp++; if (exc !== 1'b0 || rdo !== 5'd13) begin n_bad++; $display("FAIL div_int_min exc/rd: got %b/%0d expected 0/13", exc, rdo); end
  endtask

  task automatic test_div_zero();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b1, 32'sd9, 32'sd0, 5'd6, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 1)     begin n_bad++; $display("FAIL div0 latency: got %0d expected 1", lat); end
    n_cmp++; if (st0 !== 1'b1 || std !== 1'b0) begin n_bad++; $display("FAIL div0 stall start/done: got %b/%b expected 1/0", st0, std); end
    n_cmp++; if (rdo !== 5'd30) begin n_bad++; $display("FAIL div0 rd_out: got %0d expected 30", rdo); end
    n_cmp++; if (res !== 32'd5 || exc !== 1'b1) begin n_bad++; $display("FAIL div0 result/exc: got %h/%b expected 5/1", res, exc); end
  endtask

  task automatic test_flush_idle_done();
    logic st0;
    // start together with flush is ignored
    @(negedge clock);
    is_div = 1'b0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1; start = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_idle stall: got %b expected 0", stall); end
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle busy: got %b expected 0", busy); end
    // flush during DONE suppresses done
    issue(1'b1, 32'sd9, 32'sd0, 5'd6, st0);
    flush = 1'b1;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_done done: got %b expected 0", done); end
    @(negedge clock);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_done busy: got %b expected 0", busy); end
  endtask

  task automatic test_flush_run();
    logic st0, std, exc; int lat, sr, seen; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b0, 32'h1234, 32'h5678, 5'd2, st0);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL flush_run busy/stall: got %b/%b expected 0/0", busy, stall); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done === 1'b1) seen++;
      @(negedge clock);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_run done cycles: got %0d expected 0", seen); end
    issue(1'b0, 32'd2, 32'd3, 5'd8, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 33 || res !== 32'd6) begin n_bad++; $display("FAIL flush_run next op lat/result: got %0d/%h expected 33/6", lat, res); end
    n_cmp++; if (rdo !== 5'd8) begin n_bad++; $display("FAIL flush_run next op rd_out: got %0d expected 8", rdo); end
  endtask

  task automatic test_reset_mid();
    logic st0, std, exc; int lat, sr; logic [W-1:0] res; logic [4:0] rdo;
    issue(1'b0, 32'd100, 32'd100, 5'd9, st0);
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy/stall/done: got %b%b%b expected 000", busy, stall, done); end
    n_cmp++; if (result !== 32'h0 || rd_out !== 5'd0 || exception !== 1'b0) begin n_bad++; $display("FAIL reset_mid result/rd/exc: got %h/%0d/%b expected 0/0/0", result, rd_out, exception); end
    @(negedge clock);
    reset_n = 1'b1;
    issue(1'b0, -32'sd4, 32'sd5, 5'd7, st0);
    wait_done(lat, sr, std, res, rdo, exc);
    n_cmp++; if (lat !== 33 || res !== 32'hFFFFFFEC) begin n_bad++; $display("FAIL reset_mid next op lat/result: got %0d/%h expected 33/ffffffec", lat, res); end
    n_cmp++; if (rdo !== 5'd7 || exc !== 1'b0) begin n_bad++; $display("FAIL reset_mid next op rd/exc: got %0d/%b expected 7/0", rdo, exc); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_overflow();
    test_mul_min_boundary();
    test_div_signed();
    test_div_int_min();
    test_div_zero();
    test_flush_idle_done();
    test_flush_run();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
